// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C transaction arbiter.
//   arb_state_e  : arbiter FSM state encoding (IDLE, LAUNCH, XFER, GAP)
//   DEF_*        : default widths and timing used by i2c_txn_arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for a request
    LAUNCH = 2'd1,  // START_STB raised, waiting for START on the bus
    XFER   = 2'd2,  // transaction in flight, waiting for STOP
    GAP    = 2'd3   // enforced bus free time
  } arb_state_e;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_GAP_CYC = 8;

endpackage

// File: rtl/i2c_cond_detect.sv
// I2C bus condition detector. Registers SCL and the effective SDA
// (open-drain with pull-up) once, keeps the previous registered sample,
// and flags START / STOP / SCL-edge events from those two samples.
// Written so a slave-side monitor can reuse it unchanged.
//   clk, rst            : clock, synchronous active-high reset
//   scl, sda_out, sda_oe: raw pin view of the master
//   start_det           : sda fell while SCL high in both samples
//   stop_det            : sda rose while SCL high in both samples
//   scl_edge            : SCL changed between the two samples
module i2c_cond_detect (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_out,
  input  logic sda_oe,
  output logic start_det,
  output logic stop_det,
  output logic scl_edge
);

  logic scl_d, scl_q, scl_p_q;
  logic sda_d, sda_q, sda_p_q;

  // Released SDA reads high through the pull-up.
  always_comb begin
    scl_d = scl;
    sda_d = sda_oe ? sda_out : 1'b1;
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      scl_p_q <= scl_q;
      sda_p_q <= sda_q;
    end
  end

  assign start_det = scl_q & scl_p_q &  sda_p_q & ~sda_q;
  assign stop_det  = scl_q & scl_p_q & ~sda_p_q &  sda_q;
  assign scl_edge  = scl_q ^ scl_p_q;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// One transaction per grant; progress is tracked by watching the master's
// pins for START and STOP, with an SCL-inactivity timeout.
//   CLK, RESET          : clock, synchronous active-high reset
//   REQ/REQ_RNW         : per-requester request level and direction
//   REQ_ADDR/REQ_WDATA  : packed per-requester address / write data
//   GNT/DONE/ERR        : one-hot grant, completion pulse, timeout pulse
//   RDATA               : last read data, updated on a read DONE
//   START_STB/RNW/I2C_ADDR/WR_DATA : command to the master
//   RD_DATA, SCL, SDA_OUT, SDA_OE  : status / pins from the master
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          REQ_RNW,
  input  logic [N_REQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [N_REQ*DATA_W-1:0]   REQ_WDATA,
  output logic [N_REQ-1:0]          GNT,
  output logic [N_REQ-1:0]          DONE,
  output logic [N_REQ-1:0]          ERR,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      START_STB,
  output logic                      RNW,
  output logic [ADDR_W-1:0]         I2C_ADDR,
  output logic [DATA_W-1:0]         WR_DATA,
  input  logic [DATA_W-1:0]         RD_DATA,
  input  logic                      SCL,
  input  logic                      SDA_OUT,
  input  logic                      SDA_OE
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  // Round-robin search starting just after 'last'. Walks the candidates
  // from farthest to nearest so the nearest requesting one wins.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  logic start_det, stop_det, scl_edge;

  i2c_cond_detect u_cond (
    .clk       (CLK),
    .rst       (RESET),
    .scl       (SCL),
    .sda_out   (SDA_OUT),
    .sda_oe    (SDA_OE),
    .start_det (start_det),
    .stop_det  (stop_det),
    .scl_edge  (scl_edge)
  );

  arb_state_e          state_d, state_q;
  logic [IDX_W-1:0]    last_d,  last_q;
  logic [IDX_W-1:0]    gidx_d,  gidx_q;
  logic [TMR_W-1:0]    timer_d, timer_q;
  logic [GAP_W-1:0]    gap_d,   gap_q;
  logic [N_REQ-1:0]    gnt_d,   gnt_q;
  logic [N_REQ-1:0]    done_d,  done_q;
  logic [N_REQ-1:0]    err_d,   err_q;
  logic [DATA_W-1:0]   rdata_d, rdata_q;
  logic                stb_d,   stb_q;
  logic                rnw_d,   rnw_q;
  logic [ADDR_W-1:0]   addr_d,  addr_q;
  logic [DATA_W-1:0]   wdata_d, wdata_q;

  logic [IDX_W:0]      pick;
  logic [IDX_W-1:0]    pidx;
  logic [TMR_W-1:0]    tmr_inc;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    stb_d   = stb_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    pick    = rr_pick(REQ, last_q);
    pidx    = pick[IDX_W-1:0];
    // Inactivity timer: any SCL edge proves the master is alive.
    tmr_inc = scl_edge ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          gidx_d      = pidx;
          gnt_d       = '0;
          gnt_d[pidx] = 1'b1;
          addr_d      = REQ_ADDR[int'(pidx)*ADDR_W +: ADDR_W];
          wdata_d     = REQ_WDATA[int'(pidx)*DATA_W +: DATA_W];
          rnw_d       = REQ_RNW[pidx];
          stb_d       = 1'b1;
          timer_d     = '0;
          state_d     = LAUNCH;
        end
      end

      LAUNCH, XFER: begin
        timer_d = tmr_inc;
        // STOP only counts once the START has been seen; a STOP pattern
        // during LAUNCH and a repeated START during XFER are ignored.
        if (state_q == XFER && stop_det) begin
          done_d[gidx_q] = 1'b1;
          if (rnw_q) rdata_d = RD_DATA;
          gnt_d   = '0;
          last_d  = gidx_q;
          gap_d   = '0;
          state_d = GAP;
        end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
          err_d[gidx_q] = 1'b1;
          stb_d   = 1'b0;
          gnt_d   = '0;
          last_d  = gidx_q;
          gap_d   = '0;
          state_d = GAP;
        end else if (state_q == LAUNCH && start_det) begin
          stb_d   = 1'b0;
          state_d = XFER;
        end
      end

      GAP: begin
        // Exactly GAP_CYC cycles here; requests wait until IDLE.
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + GAP_W'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);  // requester 0 first after reset
      gidx_q  <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      stb_q   <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign GNT       = gnt_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RDATA     = rdata_q;
  assign START_STB = stb_q;
  assign RNW       = rnw_q;
  assign I2C_ADDR  = addr_q;
  assign WR_DATA   = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: a pin-level I2C master model plus a
// round-robin reference (nearest requester after the last winner).
module tb_i2c_txn_arbiter;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 1023;
  localparam int GAP_CYC = 8;

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic [N_REQ-1:0]        REQ, REQ_RNW;
  logic [N_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [N_REQ*DATA_W-1:0] REQ_WDATA;
  logic [N_REQ-1:0]        GNT, DONE, ERR;
  logic [DATA_W-1:0]       RDATA, WR_DATA, RD_DATA;
  logic                    START_STB, RNW, SCL, SDA_OUT, SDA_OE;
  logic [ADDR_W-1:0]       I2C_ADDR;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int done_cyc, stb_cyc, prev_done, lat;
  int m_last;
  logic [DATA_W-1:0] m_rdata;
  logic [N_REQ-1:0]  evt_acc;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  i2c_txn_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_RNW(REQ_RNW),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .START_STB(START_STB), .RNW(RNW),
    .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA),
    .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance on falling edges, remembering any DONE/ERR seen on the way.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      evt_acc = evt_acc | DONE | ERR;
    end
  endtask

  // Winner = requesting index with the smallest forward distance from last.
  function automatic int m_pick(input logic [N_REQ-1:0] r, input int last);
    int best, bd, d;
    best = 0;
    bd   = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i - last - 1 + 2 * N_REQ) % N_REQ;
      if (r[i] && d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic rnw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    REQ_RNW[i] = rnw;
    REQ_ADDR[i*ADDR_W +: ADDR_W]  = a;
    REQ_WDATA[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic bus_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1; cyc(2);
    SDA_OUT = 1'b0; cyc(2);
    SCL = 1'b0; cyc(2);
  endtask

  task automatic bus_bits(input int n);
    for (int i = 0; i < n; i++) begin
      SDA_OUT = 1'($urandom); cyc(1);
      SCL = 1'b1; cyc(2);
      SCL = 1'b0; cyc(1);
    end
  endtask

  task automatic bus_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0; cyc(2);
    SCL = 1'b1; cyc(2);
    SDA_OE = 1'b0; SDA_OUT = 1'b1; cyc(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   GNT, 0);
    chk({tag, "_done"},  DONE, 0);
    chk({tag, "_err"},   ERR, 0);
    chk({tag, "_rdata"}, RDATA, 0);
    chk({tag, "_stb"},   START_STB, 0);
    chk({tag, "_rnw"},   RNW, 0);
    chk({tag, "_addr"},  I2C_ADDR, 0);
    chk({tag, "_wdata"}, WR_DATA, 0);
  endtask

  // mode 0: normal, 1: master stuck (timeout), 2: STOP glitch before START,
  // 3: RESET pulse in the middle of XFER.
  task automatic run_txn(input int mode, input logic [DATA_W-1:0] rd,
                         input bit drop, output int lat_o);
    int w, t;
    logic [N_REQ-1:0] oh;
    w = m_pick(REQ, m_last);
    oh = '0;
    oh[w] = 1'b1;
    lat_o = 0;
    do begin cyc(1); lat_o++; end while (!START_STB && lat_o < 64);
    stb_cyc = cyc_n;
    chk("launch", START_STB, 1);
    chk("gnt", GNT, oh);
    chk("addr", I2C_ADDR, REQ_ADDR[w*ADDR_W +: ADDR_W]);
    chk("rnw", RNW, REQ_RNW[w]);
    chk("wdata", WR_DATA, REQ_WDATA[w*DATA_W +: DATA_W]);
    if (drop) REQ[w] = 1'b0;

    if (mode == 1) begin
      t = 0;
      while (ERR == '0 && t < TIMEOUT + 50) begin cyc(1); t++; end
      done_cyc = cyc_n;
      chk("tmo_lat", t, TIMEOUT);
      chk("tmo_err", ERR, oh);
      chk("tmo_done", DONE, 0);
      chk("tmo_stb", START_STB, 0);
      chk("tmo_gnt", GNT, 0);
      chk("tmo_rdata", RDATA, m_rdata);
      m_last = w;
      cyc(1);
      chk("err_pulse", ERR, 0);
      return;
    end

    evt_acc = '0;
    if (mode == 2) begin
      SCL = 1'b0; cyc(2);
      SDA_OE = 1'b1; SDA_OUT = 1'b0; cyc(2);
      SCL = 1'b1; cyc(2);
      SDA_OE = 1'b0; SDA_OUT = 1'b1; cyc(4);
      chk("glitch_stb", START_STB, 1);
      chk("glitch_gnt", GNT, oh);
      chk("glitch_evt", evt_acc, 0);
    end

    RD_DATA = rd;
    bus_start();
    t = 0;
    while (START_STB && t < 8) begin cyc(1); t++; end
    chk("stb_drop", START_STB, 0);

    if (mode == 3) begin
      bus_bits(2);
      RESET = 1'b1; SCL = 1'b1; SDA_OE = 1'b0; SDA_OUT = 1'b1;
      cyc(1);
      RESET = 1'b0;
      chk_all_zero("rst");
      m_last  = N_REQ - 1;
      m_rdata = '0;
      evt_acc = '0;
      cyc(4);
      chk("rst_noevt", evt_acc, 0);
      return;
    end

    bus_bits($urandom_range(2, 6));
    chk("xfer_gnt", GNT, oh);
    chk("early_evt", evt_acc, 0);
    bus_stop();
    t = 0;
    while (DONE == '0 && ERR == '0 && t < 10) begin cyc(1); t++; end
    done_cyc = cyc_n;
    chk("done", DONE, oh);
    chk("err0", ERR, 0);
    if (REQ_RNW[w]) m_rdata = rd;
    chk("rdata", RDATA, m_rdata);
    chk("gnt_off", GNT, 0);
    m_last = w;
    cyc(1);
    chk("done_pulse", DONE, 0);
  endtask

  initial begin
    RESET = 1'b1; REQ = '0; REQ_RNW = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    RD_DATA = '0; SCL = 1'b1; SDA_OUT = 1'b1; SDA_OE = 1'b0;
    m_last = N_REQ - 1; m_rdata = '0; evt_acc = '0;
    cyc(3);
    chk_all_zero("reset");
    RESET = 1'b0;
    cyc(2);

    // single write from requester 0
    set_req(0, 1'b0, 7'd26, 16'hA5C3);
    REQ = 2'b01;
    run_txn(0, 16'h1234, 1'b0, lat);
    chk("lat_wr", lat, 1);
    REQ = '0; cyc(12);

    // single read from requester 1
    set_req(1, 1'b1, 7'd26, 16'h0F0F);
    REQ = 2'b10;
    run_txn(0, 16'hB900, 1'b0, lat);
    chk("lat_rd", lat, 1);
    chk("rd_hold", RDATA, 16'hB900);
    REQ = '0; cyc(12);

    // contention: alternating grants with the full bus-free gap
    set_req(0, 1'b0, 7'h11, 16'hAAAA);
    set_req(1, 1'b1, 7'h22, 16'h5555);
    REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      prev_done = done_cyc;
      run_txn(0, DATA_W'($urandom), 1'b0, lat);
      if (k > 0) chk("gap", stb_cyc - prev_done, GAP_CYC + 1);
    end

    // timeout, then the other requester is served after the gap
    prev_done = done_cyc;
    run_txn(1, 16'h0, 1'b0, lat);
    chk("gap_pre_tmo", stb_cyc - prev_done, GAP_CYC + 1);
    prev_done = done_cyc;
    run_txn(0, 16'hC0DE, 1'b0, lat);
    chk("gap_tmo", stb_cyc - prev_done, GAP_CYC + 1);
    REQ = '0; cyc(12);

    // STOP pattern before START must be ignored
    REQ = 2'b01;
    run_txn(2, 16'h7777, 1'b0, lat);
    REQ = '0; cyc(12);

    // reset during XFER, then requester 0 wins first
    REQ = 2'b11;
    run_txn(3, 16'h4321, 1'b0, lat);
    run_txn(0, 16'h8765, 1'b0, lat);
    REQ = '0; cyc(12);

    // randomized traffic, sometimes dropping REQ after the grant
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N_REQ; i++)
        set_req(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      REQ = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_txn(0, DATA_W'($urandom), ($urandom_range(0, 3) == 0), lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
